// File: rtl/display_driver_bcd.sv
// Binary-to-BCD seven-segment display driver: sequential double-dabble, one bit per clock.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module display_driver_bcd #(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 3,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [WIDTH-1:0]      i_value,
  input  logic                  i_negative,
  input  logic                  i_overflow,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [8*DIGITS-1:0]   o_display
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [8*DIGITS-1:0] INV_MASK = (SEG_ACTIVE_LOW != 0) ? {(8*DIGITS){1'b1}} : {(8*DIGITS){1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_UPDATE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WIDTH-1:0]    r_bin;
  logic [BW-1:0]       r_bcd;
  logic [CW-1:0]       r_cnt;
  logic                r_neg;
  logic                r_ovf;
  logic                r_range;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [8*DIGITS-1:0] r_display;

  logic [BW-1:0]       w_bcd_adj;
  logic                w_error;
  logic [8*DIGITS-1:0] w_disp_next;
  logic [3:0]          w_digit;
  logic [7:0]          w_code;
`ifdef LEADING_ZERO_BLANK_EN
  logic                w_seen;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_load) w_state_next = ST_CONVERT;
        else        w_state_next = ST_IDLE;
      end
      ST_CONVERT: begin
        if (r_cnt == CW'(1)) w_state_next = ST_UPDATE;
        else                 w_state_next = ST_CONVERT;
      end
      ST_UPDATE: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Add-3 correction on every nibble ahead of the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      else                         w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4];
    end
  end

  assign w_error = r_ovf | r_range;

  // Segment codes for the finished BCD value, scanned from the top digit down
  always_comb begin
    w_disp_next = '0;
    w_digit     = 4'd0;
    w_code      = 8'h00;
`ifdef LEADING_ZERO_BLANK_EN
    w_seen      = 1'b0;
`endif
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_digit = r_bcd[4*k +: 4];
      w_code  = {1'b0, seg_decode(w_digit)};
`ifdef LEADING_ZERO_BLANK_EN
      if ((w_digit != 4'd0) || (k == 0)) w_seen = 1'b1;
      else                               w_seen = w_seen;
      if (!w_seen) w_code = 8'h00;
      else         w_code = w_code;
`endif
      if (w_error)                           w_code    = 8'h40;
      else if ((k == DIGITS - 1) && r_neg)   w_code[7] = 1'b1;
      else                                   w_code    = w_code;
      w_disp_next[8*k +: 8] = w_code;
    end
  end

  // Datapath and registered status outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
      r_range   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_display <= INV_MASK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_bin   <= i_value;
            r_neg   <= i_negative;
            r_ovf   <= i_overflow;
            r_bcd   <= '0;
            r_range <= 1'b0;
            r_cnt   <= CW'(WIDTH);
            r_busy  <= 1'b1;
          end
        end
        ST_CONVERT: begin
          r_bcd   <= {w_bcd_adj[BW-2:0], r_bin[WIDTH-1]};
          r_bin   <= {r_bin[WIDTH-2:0], 1'b0};
          r_range <= r_range | w_bcd_adj[BW-1];
          r_cnt   <= r_cnt - CW'(1);
        end
        ST_UPDATE: begin
          r_display <= w_disp_next ^ INV_MASK;
          r_error   <= w_error;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_error   = r_error;
  assign o_display = r_display;

endmodule

// File: tb/tb_display_driver_bcd.sv
// Self-checking bench for display_driver_bcd: three parameterisations share stimulus,
// checked against hand-written vectors and an arithmetic decimal-digit model.
module tb_display_driver_bcd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  value = 8'd0;
  logic        neg = 1'b0;
  logic        ovf = 1'b0;

  logic        busy1, done1, err1;
  logic [23:0] disp1;
  logic        busy2, done2, err2;
  logic [15:0] disp2;
  logic        busy3, done3, err3;
  logic [23:0] disp3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  display_driver_bcd #(.WIDTH(8), .DIGITS(3), .SEG_ACTIVE_LOW(0)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_value(value), .i_negative(neg),
    .i_overflow(ovf), .o_busy(busy1), .o_done(done1), .o_error(err1), .o_display(disp1));

  display_driver_bcd #(.WIDTH(8), .DIGITS(2), .SEG_ACTIVE_LOW(0)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_value(value), .i_negative(neg),
    .i_overflow(ovf), .o_busy(busy2), .o_done(done2), .o_error(err2), .o_display(disp2));

  display_driver_bcd #(.WIDTH(8), .DIGITS(3), .SEG_ACTIVE_LOW(1)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_value(value), .i_negative(neg),
    .i_overflow(ovf), .o_busy(busy3), .o_done(done3), .o_error(err3), .o_display(disp3));

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic bit model_err(input int v, input bit n_in, input bit o_in, input int nd);
    return o_in || (v >= pow10(nd));
  endfunction

  // Decimal digits by division; leading-zero rule: digit k>0 is blank when v < 10^k
  function automatic logic [39:0] model_disp(input int v, input bit n_in, input bit o_in,
                                             input int nd, input bit al);
    logic [7:0]  segtab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    logic [39:0] r = 40'd0;
    logic [7:0]  code;
    bit          e = model_err(v, n_in, o_in, nd);
    for (int k = 0; k < nd; k++) begin
      code = segtab[(v / pow10(k)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && v < pow10(k)) code = 8'h00;
`endif
      if (e) code = 8'h40;
      else if (k == nd - 1 && n_in) code[7] = 1'b1;
      if (al) code = ~code;
      r[8*k +: 8] = code;
    end
    return r;
  endfunction

  task automatic convert_and_check(input logic [7:0] v, input bit n_in, input bit o_in,
                                   input logic [23:0] exp1, input bit experr1);
    int  cnt = 1;
    bit  seen = 1'b0;
    @(negedge clk);
    value = v; neg = n_in; ovf = o_in; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    value = 8'($urandom); neg = 1'($urandom); ovf = 1'($urandom);
    chk("busy_after_load", {39'd0, busy1}, 40'd1);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (done1) seen = 1'b1;
      else cnt++;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done expected done within 50 cycles");
    end else begin
      chk("busy_cycles", 40'(cnt), 40'd9);
      chk("busy_at_done", {39'd0, busy1}, 40'd0);
      chk("disp1", {16'd0, disp1}, {16'd0, exp1});
      chk("err1", {39'd0, err1}, {39'd0, experr1});
      chk("disp1_model", {16'd0, disp1}, model_disp(v, n_in, o_in, 3, 1'b0));
      chk("done2", {39'd0, done2}, 40'd1);
      chk("disp2", {24'd0, disp2}, model_disp(v, n_in, o_in, 2, 1'b0));
      chk("err2", {39'd0, err2}, {39'd0, model_err(v, n_in, o_in, 2)});
      chk("disp3", {16'd0, disp3}, model_disp(v, n_in, o_in, 3, 1'b1));
      chk("err3", {39'd0, err3}, {39'd0, model_err(v, n_in, o_in, 3)});
      @(posedge clk); #1;
      chk("done_one_cycle", {39'd0, done1}, 40'd0);
      chk("disp1_hold", {16'd0, disp1}, {16'd0, exp1});
    end
  endtask

  typedef struct {
    logic [7:0]  v;
    bit          n;
    bit          o;
    logic [23:0] exp;
    bit          experr;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int dones;
    int busys;
    logic [7:0] rv;
    bit rn, ro;

`ifdef LEADING_ZERO_BLANK_EN
    vecs.push_back('{8'd157, 1'b0, 1'b0, 24'h066D07, 1'b0});
    vecs.push_back('{8'd42,  1'b1, 1'b0, 24'h80665B, 1'b0});
    vecs.push_back('{8'd0,   1'b0, 1'b0, 24'h00003F, 1'b0});
    vecs.push_back('{8'd7,   1'b0, 1'b0, 24'h000007, 1'b0});
    vecs.push_back('{8'd5,   1'b0, 1'b1, 24'h404040, 1'b1});
    vecs.push_back('{8'd9,   1'b0, 1'b0, 24'h00006F, 1'b0});
    vecs.push_back('{8'd0,   1'b1, 1'b0, 24'h80003F, 1'b0});
    vecs.push_back('{8'd99,  1'b0, 1'b0, 24'h006F6F, 1'b0});
`else
    vecs.push_back('{8'd157, 1'b0, 1'b0, 24'h066D07, 1'b0});
    vecs.push_back('{8'd42,  1'b1, 1'b0, 24'hBF665B, 1'b0});
    vecs.push_back('{8'd0,   1'b0, 1'b0, 24'h3F3F3F, 1'b0});
    vecs.push_back('{8'd7,   1'b0, 1'b0, 24'h3F3F07, 1'b0});
    vecs.push_back('{8'd5,   1'b0, 1'b1, 24'h404040, 1'b1});
    vecs.push_back('{8'd9,   1'b0, 1'b0, 24'h3F3F6F, 1'b0});
    vecs.push_back('{8'd0,   1'b1, 1'b0, 24'hBF3F3F, 1'b0});
    vecs.push_back('{8'd99,  1'b0, 1'b0, 24'h3F6F6F, 1'b0});
`endif
    vecs.push_back('{8'd100, 1'b0, 1'b0, 24'h063F3F, 1'b0});
    vecs.push_back('{8'd200, 1'b0, 1'b0, 24'h5B3F3F, 1'b0});
    vecs.push_back('{8'd255, 1'b1, 1'b0, 24'hDB6D6D, 1'b0});

    // reset values
    #12;
    chk("rst_busy", {39'd0, busy1}, 40'd0);
    chk("rst_done", {39'd0, done1}, 40'd0);
    chk("rst_err", {39'd0, err1}, 40'd0);
    chk("rst_disp1", {16'd0, disp1}, 40'd0);
    chk("rst_disp3", {16'd0, disp3}, 40'hFFFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) convert_and_check(vecs[i].v, vecs[i].n, vecs[i].o, vecs[i].exp, vecs[i].experr);

    // Load held high: back-to-back conversions, one Done per conversion
    @(negedge clk);
    value = 8'd157; neg = 1'b0; ovf = 1'b0; load = 1'b1;
    dones = 0; busys = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done1) dones++;
      if (busy1) busys++;
    end
    load = 1'b0;
    chk("held_load_dones", 40'(dones), 40'd3);
    chk("held_load_busy", 40'(busys), 40'd27);
    repeat (3) @(posedge clk);
    #1;
    chk("held_load_idle", {39'd0, busy1}, 40'd0);

    // Reset in the middle of a conversion
    @(negedge clk);
    value = 8'd42; neg = 1'b1; ovf = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {39'd0, busy1}, 40'd0);
    chk("midrst_disp1", {16'd0, disp1}, 40'd0);
    chk("midrst_disp3", {16'd0, disp3}, 40'hFFFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done1) dones++;
    end
    chk("midrst_no_done", 40'(dones), 40'd0);
    chk("midrst_disp_kept", {16'd0, disp1}, 40'd0);

    // Randomized conversions against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rv = 8'($urandom);
      rn = 1'($urandom);
      ro = ($urandom_range(0, 7) == 0);
      convert_and_check(rv, rn, ro, model_disp(rv, rn, ro, 3, 1'b0)[23:0], model_err(rv, rn, ro, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
